// File: rtl/spi_master_fifo.sv
// SPI master with programmable frame length, CPOL/CPHA, bit order and
// TX/RX FIFOs behind a 32-bit register port with combinational read.
module spi_master_fifo #(
    parameter int NUM_CS     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       data_i,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    output logic [31:0]       data_o,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_ss,
    output logic              spi_clk
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t state, state_nx;

    logic              en, cpol, cpha, lsb, auto_cs;
    logic [7:0]        div;
    logic [4:0]        len;
    logic [NUM_CS-1:0] cs;
    logic              tx_ovf, rx_ovf;

    logic [31:0]   tx_mem [FIFO_DEPTH];
    logic [31:0]   rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [31:0]   tx_head;

    logic [7:0]  cnt;
    logic [5:0]  edges;
    logic [4:0]  in_idx, out_idx;
    logic [31:0] txd, rxd;
    logic        sclk_q, mosi_q;

    logic [4:0] a;
    logic       wr_ctrl, wr_data, wr_stat, wr_pop, wr_cs;
    logic       tx_full, tx_empty, rx_full, rx_empty;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       tx_drop, rx_drop;
    logic       tick, odd, last, smp, sho;
    logic       busy, frame_active;
    logic [7:0] tx_cnt8, rx_cnt8;
    logic       unused_addr;

    assign a           = addr_i[4:0];
    assign unused_addr = ^addr_i[31:5];

    assign wr_ctrl = we_i && (a == 5'h00);
    assign wr_data = we_i && (a == 5'h04);
    assign wr_stat = we_i && (a == 5'h08);
    assign wr_pop  = we_i && (a == 5'h0C);
    assign wr_cs   = we_i && (a == 5'h10);

    assign tx_full  = tx_cnt == CW'(FIFO_DEPTH);
    assign tx_empty = tx_cnt == '0;
    assign rx_full  = rx_cnt == CW'(FIFO_DEPTH);
    assign rx_empty = rx_cnt == '0;
    assign tx_head  = tx_mem[tx_rd];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign tx_pop  = (state == LOAD) && !tx_empty;
    assign tx_push = wr_data && (!tx_full || tx_pop);
    assign tx_drop = wr_data && tx_full && !tx_pop;
    assign rx_pop  = wr_pop && !rx_empty;
    assign rx_push = (state == DONE) && (!rx_full || rx_pop);
    assign rx_drop = (state == DONE) && rx_full && !rx_pop;

    assign tick = (state == SHIFT) && (cnt == div);
    assign odd  = ~edges[0];
    assign last = edges == {len, 1'b1};
    assign smp  = tick && (cpha ? !odd : odd);
    assign sho  = tick && (cpha ? odd : (!odd && !last));

    assign busy         = state != IDLE;
    assign frame_active = state != IDLE;
    assign tx_cnt8      = 8'(tx_cnt);
    assign rx_cnt8      = 8'(rx_cnt);

    assign spi_clk  = (state == SHIFT) ? sclk_q : cpol;
    assign spi_mosi = mosi_q;
    assign spi_ss   = auto_cs ? ~(cs & {NUM_CS{frame_active}}) : ~cs;

    function automatic logic [4:0] pos(input logic [4:0] k);
        return lsb ? k : len - k;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en      <= 1'b0;
            cpol    <= 1'b0;
            cpha    <= 1'b0;
            lsb     <= 1'b0;
            auto_cs <= 1'b0;
            div     <= '0;
            len     <= '0;
            cs      <= '0;
            tx_ovf  <= 1'b0;
            rx_ovf  <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en      <= data_i[0];
                cpol    <= data_i[1];
                cpha    <= data_i[2];
                lsb     <= data_i[3];
                auto_cs <= data_i[4];
                div     <= data_i[15:8];
                len     <= data_i[20:16];
            end
            if (wr_cs) cs <= data_i[NUM_CS-1:0];
            // A new overflow wins over a same-cycle clear
            tx_ovf <= (tx_ovf && !(wr_stat && data_i[5])) || tx_drop;
            rx_ovf <= (rx_ovf && !(wr_stat && data_i[6])) || rx_drop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_rd  <= '0;
            tx_wr  <= '0;
            tx_cnt <= '0;
            rx_rd  <= '0;
            rx_wr  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= data_i;
        if (rx_push) rx_mem[rx_wr] <= rxd;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (en && (!tx_empty || wr_data)) state_nx = LOAD;
            LOAD:  state_nx = SHIFT;
            SHIFT: if (tick && last) state_nx = DONE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            edges   <= '0;
            in_idx  <= '0;
            out_idx <= '0;
            txd     <= '0;
            rxd     <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                LOAD: begin
                    txd     <= tx_head;
                    rxd     <= '0;
                    cnt     <= '0;
                    edges   <= '0;
                    in_idx  <= '0;
                    sclk_q  <= cpol;
                    out_idx <= cpha ? 5'd0 : 5'd1;
                    if (!cpha) mosi_q <= tx_head[pos(5'd0)];
                end
                SHIFT: begin
                    if (tick) begin
                        cnt    <= '0;
                        edges  <= edges + 6'd1;
                        sclk_q <= ~sclk_q;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                    if (smp) begin
                        rxd[pos(in_idx)] <= spi_miso;
                        in_idx <= in_idx + 5'd1;
                    end
                    if (sho) begin
                        mosi_q  <= txd[pos(out_idx)];
                        out_idx <= out_idx + 5'd1;
                    end
                end
                IDLE, DONE: ;
            endcase
        end
    end

    always_comb begin
        data_o = '0;
        case (a)
            5'h00: data_o = {11'd0, len, div, 3'd0,
                             auto_cs, lsb, cpha, cpol, en};
            5'h04: data_o = rx_empty ? 32'd0 : rx_mem[rx_rd];
            5'h08: data_o = {8'd0, rx_cnt8, tx_cnt8, 1'b0,
                             rx_ovf, tx_ovf, rx_empty, rx_full,
                             tx_empty, tx_full, busy};
            5'h10: data_o = 32'(cs);
            default: data_o = '0;
        endcase
    end

endmodule
